// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller.
// One full-adder cell (two half adders plus an OR) is reused for every bit
// of a W-bit operation, LSB first, one bit per clock. The result, final carry
// and signed overflow are registered. A one-cycle done pulse marks completion.

module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module serial_adder_ctrl #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         carry_out,
  output logic         overflow
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [W-1:0]  sa;
  logic [W-1:0]  sb;
  logic          cin;
  logic [CW-1:0] cnt;
  logic [W-1:0]  wr;
  logic [W-1:0]  wr_next;

  logic ha0_s, ha0_c, ha1_s, ha1_c;
  logic fa_s, fa_c;

  // Shared 1-bit cell: the subtract inversion and the +1 are already folded
  // into sb and the initial cin, so the cell only ever adds.
  half_adder u_ha0 (.x(sa[0]), .y(sb[0]), .s(ha0_s), .c(ha0_c));
  half_adder u_ha1 (.x(ha0_s), .y(cin),   .s(ha1_s), .c(ha1_c));

  assign fa_s = ha1_s;
  assign fa_c = ha0_c | ha1_c;

  // Each new sum bit enters at the MSB so that after W steps bit i holds step i.
  generate
    if (W == 1) begin : g_wr1
      assign wr_next = fa_s;
    end else begin : g_wrn
      assign wr_next = {fa_s, wr[W-1:1]};
    end
  endgenerate

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Sequencer: operand capture in IDLE, one bit-step per edge in RUN,
  // result registers loaded on the final step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sa        <= '0;
      sb        <= '0;
      cin       <= 1'b0;
      cnt       <= '0;
      wr        <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= sub ? ~b : b;
            cin   <= sub;
            cnt   <= '0;
            wr    <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          cin <= fa_c;
          wr  <= wr_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            // cin here is the carry into the MSB; overflow is its XOR with
            // the carry out of the MSB.
            sum       <= wr_next;
            carry_out <= fa_c;
            overflow  <= cin ^ fa_c;
            cnt       <= '0;
            state     <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
